// File: rtl/device_id_reader.sv
// Register-bus initiator that scans a device ID register block, captures identity words,
// checks the MD5 words against an expected value and streams every word it reads.
module device_id_reader #(
  parameter int unsigned              NUM_REGS       = 32,
  parameter int unsigned              ADDR_WIDTH     = 16,
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [4*DATA_WIDTH-1:0]  EXP_MD5        = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic                  err_bad_data_o,
  output logic                  md5_match_o,
  output logic [DATA_WIDTH-1:0] dev_id_o,
  output logic [DATA_WIDTH-1:0] revision_o,
  output logic                  rd_word_valid_o,
  output logic [ADDR_WIDTH-1:0] rd_word_addr_o,
  output logic [DATA_WIDTH-1:0] rd_word_data_o,
  output logic                  reg_req_o,
  output logic                  reg_rd_wr_l_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wr_data_o,
  input  logic                  reg_ack_i,
  input  logic [DATA_WIDTH-1:0] reg_rd_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] Md5Words = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] DevIdAddr = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] RevAddr = ADDR_WIDTH'(5);
  localparam logic [15:0]           CntLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] BadWord = DATA_WIDTH'(32'hDEAD_BEEF);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  md5_ok_q, md5_ok_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_bad_q, err_bad_d;
  logic                  md5_match_q, md5_match_d;
  logic [DATA_WIDTH-1:0] dev_id_q, dev_id_d;
  logic [DATA_WIDTH-1:0] revision_q, revision_d;
  logic                  word_valid_q, word_valid_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [DATA_WIDTH-1:0] word_data_q, word_data_d;
  logic [DATA_WIDTH-1:0] md5_exp;

  // MD5_0 sits in the most significant slice of EXP_MD5.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    md5_exp = EXP_MD5[4*DATA_WIDTH-1:3*DATA_WIDTH];
      2'd1:    md5_exp = EXP_MD5[3*DATA_WIDTH-1:2*DATA_WIDTH];
      2'd2:    md5_exp = EXP_MD5[2*DATA_WIDTH-1:DATA_WIDTH];
      default: md5_exp = EXP_MD5[DATA_WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    md5_ok_d      = md5_ok_q;
    err_timeout_d = err_timeout_q;
    err_bad_d     = err_bad_q;
    md5_match_d   = md5_match_q;
    dev_id_d      = dev_id_q;
    revision_d    = revision_q;
    word_valid_d  = 1'b0;
    word_addr_d   = word_addr_q;
    word_data_d   = word_data_q;
    reg_req_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d       = StReq;
          err_timeout_d = 1'b0;
          err_bad_d     = 1'b0;
          md5_match_d   = 1'b0;
          addr_d        = '0;
          cnt_d         = '0;
          md5_ok_d      = 1'b1;
        end
      end
      StReq: begin
        reg_req_o = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        // An ack takes priority over a timeout expiring in the same cycle.
        if (reg_ack_i) begin
          word_valid_d = 1'b1;
          word_addr_d  = addr_q;
          word_data_d  = reg_rd_data_i;
          if (addr_q < Md5Words) md5_ok_d = md5_ok_q & (reg_rd_data_i == md5_exp);
          if (addr_q == DevIdAddr) dev_id_d = reg_rd_data_i;
          if (addr_q == RevAddr) revision_d = reg_rd_data_i;
          if (reg_rd_data_i == BadWord) err_bad_d = 1'b1;
          if (addr_q == LastAddr) begin
            state_d     = StDone;
            md5_match_d = md5_ok_d;
          end else begin
            state_d = StGap;
          end
        end else if (cnt_q == CntLast) begin
          state_d       = StDone;
          err_timeout_d = 1'b1;
          md5_match_d   = 1'b0;
        end
      end
      StGap: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        cnt_d   = '0;
        state_d = StReq;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      cnt_q         <= '0;
      md5_ok_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_bad_q     <= 1'b0;
      md5_match_q   <= 1'b0;
      dev_id_q      <= '0;
      revision_q    <= '0;
      word_valid_q  <= 1'b0;
      word_addr_q   <= '0;
      word_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      md5_ok_q      <= md5_ok_d;
      err_timeout_q <= err_timeout_d;
      err_bad_q     <= err_bad_d;
      md5_match_q   <= md5_match_d;
      dev_id_q      <= dev_id_d;
      revision_q    <= revision_d;
      word_valid_q  <= word_valid_d;
      word_addr_q   <= word_addr_d;
      word_data_q   <= word_data_d;
    end
  end

  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StDone);
  assign err_timeout_o   = err_timeout_q;
  assign err_bad_data_o  = err_bad_q;
  assign md5_match_o     = md5_match_q;
  assign dev_id_o        = dev_id_q;
  assign revision_o      = revision_q;
  assign rd_word_valid_o = word_valid_q;
  assign rd_word_addr_o  = word_addr_q;
  assign rd_word_data_o  = word_data_q;
  assign reg_rd_wr_l_o   = 1'b1;
  assign reg_addr_o      = addr_q;
  assign reg_wr_data_o   = '0;

endmodule

// File: tb/tb_device_id_reader.sv
// Self-checking bench for device_id_reader: register responder model, scan-level scoreboard
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_device_id_reader;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned Timeout = 10;
  localparam logic [127:0] ExpMd5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_to, err_bad, md5_match;
  logic [31:0] dev_id, revision;
  logic        wvalid;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        reg_req, reg_rd_wr_l;
  logic [15:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_ack;
  logic [31:0] reg_rd_data;

  device_id_reader #(
    .NUM_REGS      (NumRegs),
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(Timeout),
    .EXP_MD5       (ExpMd5)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .err_timeout_o  (err_to),
    .err_bad_data_o (err_bad),
    .md5_match_o    (md5_match),
    .dev_id_o       (dev_id),
    .revision_o     (revision),
    .rd_word_valid_o(wvalid),
    .rd_word_addr_o (waddr),
    .rd_word_data_o (wdata),
    .reg_req_o      (reg_req),
    .reg_rd_wr_l_o  (reg_rd_wr_l),
    .reg_addr_o     (reg_addr),
    .reg_wr_data_o  (reg_wr_data),
    .reg_ack_i      (reg_ack),
    .reg_rd_data_i  (reg_rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Responder: acks `lat` cycles after reg_req rises, once per request; never acks hang_addr.
  logic [31:0] mem [NumRegs];
  int          lat = 1;
  int          hang_addr = -1;
  int          wait_cnt;
  logic        served;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_ack     <= 1'b0;
      reg_rd_data <= '0;
      wait_cnt    <= 0;
      served      <= 1'b0;
    end else begin
      reg_ack <= 1'b0;
      if (!reg_req) begin
        served   <= 1'b0;
        wait_cnt <= 0;
      end else if (!served) begin
        if (wait_cnt + 1 >= lat) begin
          served <= 1'b1;
          if (int'(reg_addr) != hang_addr) begin
            reg_ack     <= 1'b1;
            reg_rd_data <= mem[reg_addr[4:0]];
          end
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Scoreboard model, sampled 1 time unit after every rising edge.
  bit          in_scan, prev_busy, prev_req, prev_ack, ack_in_run, exp_bad;
  int          exp_idx, edges, req_run, done_count, last_words, last_edges, last_to_run;
  logic [31:0] exp_dev = '0, exp_rev = '0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      chk("reset_req", reg_req, 0);
      chk("reset_busy", busy, 0);
      chk("reset_outs", {done, err_to, err_bad, md5_match, wvalid, dev_id, revision}, 0);
      in_scan = 0; prev_busy = 0; prev_req = 0; prev_ack = 0;
      exp_dev = '0; exp_rev = '0;
    end else begin
      if (start && !prev_busy) begin
        in_scan = 1; exp_idx = 0; exp_bad = 0; edges = 0;
      end else if (in_scan) begin
        edges++;
      end
      chk("busy", busy, in_scan);
      chk("rd_wr_l", {reg_rd_wr_l, reg_wr_data}, {1'b1, 32'h0});
      if (wvalid) begin
        chk("word_addr", waddr, exp_idx);
        chk("word_data", wdata, mem[exp_idx[4:0]]);
        if (exp_idx == 4) exp_dev = mem[4];
        if (exp_idx == 5) exp_rev = mem[5];
        if (mem[exp_idx[4:0]] == 32'hDEAD_BEEF) exp_bad = 1;
        exp_idx++;
      end
      chk("dev_id", dev_id, exp_dev);
      chk("revision", revision, exp_rev);
      if (reg_req) begin
        chk("reg_addr", reg_addr, exp_idx);
        if (!prev_req) begin req_run = 0; ack_in_run = 0; end
        req_run++;
        if (reg_ack) ack_in_run = 1;
      end
      if (prev_req && prev_ack) chk("req_drop_after_ack", reg_req, 0);
      if (prev_req && !reg_req && !ack_in_run) last_to_run = req_run;
      if (done) begin
        chk("done_in_scan", in_scan, 1);
        chk("words", exp_idx, (hang_addr >= 0) ? hang_addr : NumRegs);
        chk("err_timeout", err_to, hang_addr >= 0);
        chk("err_bad", err_bad, exp_bad);
        chk("md5_match", md5_match,
            (hang_addr < 0) && ({mem[0], mem[1], mem[2], mem[3]} == ExpMd5));
        last_words = exp_idx;
        last_edges = edges;
        done_count++;
        in_scan = 0;
      end
      prev_busy = busy;
      prev_req  = reg_req;
      prev_ack  = reg_ack;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1);
  endtask

  int d0;

  initial begin
    mem[0] = ExpMd5[127:96]; mem[1] = ExpMd5[95:64];
    mem[2] = ExpMd5[63:32];  mem[3] = ExpMd5[31:0];
    mem[4] = 32'h12; mem[5] = 32'h3; mem[6] = 32'h0000_C0C1;
    for (int i = 7; i < NumRegs; i++) mem[i] = 32'h4142_4300 + i;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean scan; done arrives 95 edges after the start edge (cycle 96).
    pulse_start();
    wait_done("t1", 200);
    chk("t1_md5", md5_match, 1);
    chk("t1_dev", dev_id, 32'h12);
    chk("t1_rev", revision, 32'h3);
    chk("t1_words", last_words, 32);
    chk("t1_latency", last_edges, 95);
    @(negedge clk);
    chk("t1_done_1cyc", done, 0);

    // 2: one bit flipped in MD5_2.
    mem[2] = mem[2] ^ 32'h0000_0020;
    pulse_start();
    wait_done("t2", 200);
    chk("t2_md5", md5_match, 0);
    chk("t2_bad", err_bad, 0);
    chk("t2_words", last_words, 32);
    mem[2] = ExpMd5[63:32];

    // 3: word 7 never acked.
    hang_addr = 7;
    pulse_start();
    wait_done("t3", 200);
    chk("t3_timeout", err_to, 1);
    chk("t3_md5", md5_match, 0);
    chk("t3_words", last_words, 7);
    chk("t3_req_run", last_to_run, 10);
    hang_addr = -1;
    @(negedge clk);

    // 4: bad word at address 20.
    mem[20] = 32'hDEAD_BEEF;
    pulse_start();
    wait_done("t4", 200);
    chk("t4_bad", err_bad, 1);
    chk("t4_md5", md5_match, 1);
    chk("t4_timeout", err_to, 0);
    mem[20] = 32'h4142_4300 + 20;

    // 5: second start mid-scan is dropped, then reset at word 10.
    d0 = done_count;
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done("t5a", 200);
    repeat (120) @(negedge clk);
    chk("t5_one_done", done_count - d0, 1);
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (wvalid && waddr == 16'd10) hit = 1;
      end
      chk("t5_word10_seen", hit, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_async_req", reg_req, 0);
    chk("t5_async_outs", {busy, done, err_to, err_bad, md5_match, wvalid, dev_id, revision}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_done("t5b", 200);
    chk("t5b_md5", md5_match, 1);
    chk("t5b_dev", dev_id, 32'h12);

    // 6: three-cycle ack latency.
    lat = 3;
    pulse_start();
    wait_done("t6", 400);
    chk("t6_words", last_words, 32);
    chk("t6_rev", revision, 32'h3);
    lat = 1;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
